spram_responder: RTL
====================

SPRAM_RESPONDER -- requirements
Module: spram_responder

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port req_valid, input, 1, request present.
REQ-004 SHALL have port req_ready, output, 1, request accepted on the edge where req_valid and req_ready are both 1.
REQ-005 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-006 SHALL have port req_addr, input, 14, word address 0..16383.
REQ-007 SHALL have port req_wdata, input, 16, write data.
REQ-008 SHALL have port req_mask, input, 4, nibble write enables; bit i covers wdata[4i+3:4i].
REQ-009 SHALL have port rsp_valid, output, 1, read data available.
REQ-010 SHALL have port rsp_ready, input, 1, consumer takes the response.
REQ-011 SHALL have port rsp_rdata, output, 16, read data.
REQ-012 SHALL have port fill_start, input, 1, level request to fill the whole memory.
REQ-013 SHALL have port fill_value, input, 16, fill word, sampled when the fill is accepted.
REQ-014 SHALL have port fill_busy, output, 1, fill in progress.
REQ-015 SHALL have port fill_done, output, 1, one-cycle pulse on fill completion.

Function
REQ-016 SHALL instantiate one SB_SPRAM256KA with the following fixed ties: ADDRESS = {2'b00, addr14}, CHIPSELECT=1, STANDBY=0, SLEEP=0, POWEROFF=1, CLOCK=clk.
REQ-017 SHALL register each accepted request into an issue stage that drives the SPRAM on the next edge; WREN and MASKWREN are active only for issued writes.
REQ-018 SHALL assert rsp_valid for a read on the 2nd rising edge after its acceptance edge, with data equal to memory content at that address after all earlier accepted writes.
REQ-019 SHALL generate no response for writes.
REQ-020 SHALL return responses in acceptance order through a 2-entry response FIFO.
REQ-021 SHALL hold rsp_valid and rsp_rdata stable until the cycle rsp_valid and rsp_ready are both 1; the entry pops on that edge.
REQ-022 SHALL keep a 2-bit credit count: +1 on read accept, -1 on response pop, unchanged when both occur on the same edge; the range is 0..2.
REQ-023 SHALL drive req_ready = (state==IDLE) and not fill_start and (credits<2), for reads and writes alike.
REQ-024 SHALL use a state machine with the states IDLE, FILL and DONE.
REQ-025 SHALL go IDLE->FILL when fill_start=1 and the issue stage is empty; fill_start takes priority over a same-cycle request.
REQ-026 SHALL have FILL write fill_value with mask 4'b1111 to addresses 0,1,...,16383, one per cycle, with fill_busy=1 for exactly 16384 cycles.
REQ-027 SHALL use a 14-bit fill counter; the write at 16383 is terminal, with FILL->DONE on that edge and no further write.
REQ-028 SHALL assert fill_done=1 for exactly one cycle in DONE, followed by DONE->IDLE; fill_start still high in IDLE starts a new fill.
REQ-029 SHALL continue draining FIFO responses during FILL and DONE.

Reset
REQ-030 SHALL, while resetn=0 (asynchronous), force state=IDLE, credits=0, FIFO empty, issue stage empty, fill counter=0, rsp_valid=0, rsp_rdata=0, fill_busy=0, fill_done=0, and SPRAM WREN=0.
REQ-031 SHALL, after resetn deassertion, present req_ready=1 unless fill_start=1.
REQ-032 SHALL abort a fill on reset mid-fill: memory contents are left partially filled (SPRAM contents are never reset) and no fill_done pulse is produced.

Verification
REQ-033 SHALL cover: write 0x1234 to addr 5, mask 1111, then read addr 5 -> rsp_valid on the 2nd edge after the read accept, with rsp_rdata=0x1234.
REQ-034 SHALL cover: write 0xFFFF to addr 7, then write 0x0000 with mask 0011, then read addr 7 -> rsp_rdata=0xFF00.
REQ-035 SHALL cover: rsp_ready=0 and back-to-back reads of addrs 0,1,2 holding 1,2,4 -> two accepted, req_ready=0; then rsp_ready=1 -> 0x0001 and 0x0002 in order, third read accepted, then 0x0004.
REQ-036 SHALL cover: fill_start with fill_value=0xA5A5 -> fill_busy high for 16384 cycles, req_ready=0 throughout, one fill_done pulse; reads of addrs 0, 8191 and 16383 return 0xA5A5.
REQ-037 SHALL cover: with credits=1 and rsp_valid=1, a simultaneous pop and read accept -> credits stay 1 and the next response carries the new read's data.
REQ-038 SHALL cover: resetn low after 100 fill writes -> fill_busy=0, rsp_valid=0, no fill_done; after release, req_ready=1, addr 99 reads 0xA5A5 and addr 100 is unchanged.

Source files
------------

// File: rtl/spram_responder.sv
// Request/response front end for one 16K x 16 single-port RAM, with a whole-memory fill engine.
// The RAM primitive model is kept in this file so the block stands alone.

module SB_SPRAM256KA (
  input  logic [15:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] mem [0:16383];
  logic        en;

  // Only the low 16K words exist; the array is powered when POWEROFF is high.
  assign en = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF & (ADDRESS[15:14] == 2'b00);

  // Synchronous RAM: nibble-masked write, or registered read. DATAOUT holds during writes.
  always_ff @(posedge CLOCK) begin
    if (en) begin
      if (WREN) begin
        for (int i = 0; i < 4; i++) begin
          if (MASKWREN[i]) mem[ADDRESS[13:0]][4*i +: 4] <= DATAIN[4*i +: 4];
        end
      end else begin
        DATAOUT <= mem[ADDRESS[13:0]];
      end
    end
  end

endmodule

module spram_responder (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [13:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  input  logic        fill_start,
  input  logic [15:0] fill_value,
  output logic        fill_busy,
  output logic        fill_done
);

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 4;
  localparam int unsigned CW = 2;
  localparam logic [AW-1:0] FILL_LAST = {AW{1'b1}};
  localparam logic [CW-1:0] CREDIT_MAX = CW'(2);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  credits_q, credits_d;
  logic           iss_v_q, iss_we_q;
  logic [AW-1:0]  iss_addr_q;
  logic [DW-1:0]  iss_wdata_q;
  logic [MW-1:0]  iss_mask_q;
  logic           rd_pend_q;
  logic [AW-1:0]  fill_cnt_q;
  logic [DW-1:0]  fill_val_q;
  logic           tail_v_q, tail_v_d, head_v_d;
  logic [DW-1:0]  tail_data_q, tail_data_d, head_data_d;
  logic           accept, rd_accept, pop;
  logic [AW-1:0]  sp_addr;
  logic [DW-1:0]  sp_din, sp_dout;
  logic [MW-1:0]  sp_mask;
  logic           sp_wren;

  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_we;
  assign pop       = rsp_valid & rsp_ready;

  // Fill has priority over requests and waits for the issue stage to drain.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = ~fill_start & (credits_q != CREDIT_MAX);
        if (fill_start && !iss_v_q) state_d = FILL;
      end
      FILL:    if (fill_cnt_q == FILL_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Credits count reads accepted but not yet popped; they bound FIFO occupancy.
  always_comb begin
    credits_d = credits_q;
    case ({rd_accept, pop})
      2'b10:   credits_d = credits_q + CW'(1);
      2'b01:   credits_d = credits_q - CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  // Two-entry FIFO whose head is the registered response port.
  always_comb begin
    head_v_d    = rsp_valid;
    head_data_d = rsp_rdata;
    tail_v_d    = tail_v_q;
    tail_data_d = tail_data_q;
    if (pop) begin
      head_v_d = tail_v_q;
      if (tail_v_q) head_data_d = tail_data_q;
      tail_v_d = 1'b0;
    end
    if (rd_pend_q) begin
      if (!head_v_d) begin
        head_v_d    = 1'b1;
        head_data_d = sp_dout;
      end else begin
        tail_v_d    = 1'b1;
        tail_data_d = sp_dout;
      end
    end
  end

  // RAM port: fill engine while filling, otherwise the issue stage.
  always_comb begin
    sp_addr = iss_addr_q;
    sp_din  = iss_wdata_q;
    sp_wren = iss_v_q & iss_we_q;
    sp_mask = (iss_v_q & iss_we_q) ? iss_mask_q : '0;
    if (state_q == FILL) begin
      sp_addr = fill_cnt_q;
      sp_din  = fill_val_q;
      sp_wren = 1'b1;
      sp_mask = '1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      credits_q   <= '0;
      iss_v_q     <= 1'b0;
      iss_we_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_wdata_q <= '0;
      iss_mask_q  <= '0;
      rd_pend_q   <= 1'b0;
      fill_cnt_q  <= '0;
      fill_val_q  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      tail_v_q    <= 1'b0;
      tail_data_q <= '0;
      fill_busy   <= 1'b0;
      fill_done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      iss_v_q     <= accept;
      if (accept) begin
        iss_we_q    <= req_we;
        iss_addr_q  <= req_addr;
        iss_wdata_q <= req_wdata;
        iss_mask_q  <= req_mask;
      end
      rd_pend_q   <= iss_v_q & ~iss_we_q;
      fill_cnt_q  <= (state_q == FILL) ? fill_cnt_q + AW'(1) : '0;
      if (state_q == IDLE && state_d == FILL) fill_val_q <= fill_value;
      rsp_valid   <= head_v_d;
      rsp_rdata   <= head_data_d;
      tail_v_q    <= tail_v_d;
      tail_data_q <= tail_data_d;
      fill_busy   <= (state_d == FILL);
      fill_done   <= (state_d == DONE);
    end
  end

  SB_SPRAM256KA u_spram (
    .ADDRESS    ({2'b00, sp_addr}),
    .DATAIN     (sp_din),
    .MASKWREN   (sp_mask),
    .WREN       (sp_wren),
    .CHIPSELECT (1'b1),
    .CLOCK      (clk),
    .STANDBY    (1'b0),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (sp_dout)
  );

endmodule
